// File: rtl/matrix_pkg.sv
// Shared matrix geometry and serializer state encoding for the matrix
// compiler/decompiler pair.
package matrix_pkg;

    localparam int unsigned ROWS   = 32;
    localparam int unsigned COLS   = 32;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned ROW_W  = COLS * ELEM_W;
    localparam int unsigned ROW_AW = $clog2(ROWS);
    localparam int unsigned COL_AW = $clog2(COLS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/row_fifo.sv
// Two-entry row buffer; exposes both the head row and the row behind it so
// the consumer can look one pop ahead.
module row_fifo #(
    parameter int unsigned W = matrix_pkg::ROW_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] head_o,
    output logic [W-1:0] second_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push_i && (count_q != 2'd2);
    assign do_pop  = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_o   = mem_q[rd_ptr_q];
    assign second_o = mem_q[~rd_ptr_q];
    assign count_o  = count_q;
    assign full_o   = (count_q == 2'd2);
    assign empty_o  = (count_q == 2'd0);

endmodule

// File: rtl/matrix_decompiler.sv
// Accepts packed matrix rows and streams them out one element per transfer,
// tagging each element with its implicit row and column index.
module matrix_decompiler #(
    parameter int unsigned ROWS   = matrix_pkg::ROWS,
    parameter int unsigned COLS   = matrix_pkg::COLS,
    parameter int unsigned ELEM_W = matrix_pkg::ELEM_W
) (
    input  logic                    eth_refclk,
    input  logic                    rst_n,
    input  logic                    valid_data_in,
    input  logic [COLS*ELEM_W-1:0]  dibit,
    output logic                    ready_out,
    output logic                    valid_data_out,
    input  logic                    ready_in,
    output logic [$clog2(ROWS)-1:0] row_addr,
    output logic [$clog2(COLS)-1:0] col_addr,
    output logic [ELEM_W-1:0]       matrix_element,
    output logic                    frame_done
);

    import matrix_pkg::*;

    localparam int unsigned ROW_BITS = COLS * ELEM_W;
    localparam int unsigned RA_W     = $clog2(ROWS);
    localparam int unsigned CA_W     = $clog2(COLS);

    ser_state_e        state_q, state_d;
    logic [RA_W-1:0]   row_q, row_d;
    logic [CA_W-1:0]   col_q, col_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic              ready_q, ready_d;
    logic              frame_q, frame_d;

    logic                push;
    logic                pop;
    logic                xfer;
    logic                last_col;
    logic [ROW_BITS-1:0] head;
    logic [ROW_BITS-1:0] second;
    logic [ROW_BITS-1:0] head_nxt;
    logic [1:0]          count;
    logic [1:0]          count_nxt;
    logic                full;
    logic                empty;

    assign push     = valid_data_in && ready_q;
    assign xfer     = (state_q == SHIFT) && ready_in;
    assign last_col = (col_q == CA_W'(COLS - 1));
    assign pop      = xfer && last_col;

    row_fifo #(
        .W (ROW_BITS)
    ) u_row_fifo (
        .clk      (eth_refclk),
        .rst_n    (rst_n),
        .push_i   (push),
        .pop_i    (pop),
        .wdata_i  (dibit),
        .head_o   (head),
        .second_o (second),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            elem_q  <= '0;
            ready_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            elem_q  <= elem_d;
            ready_q <= ready_d;
            frame_q <= frame_d;
        end
    end

    // Next state, counters, and a one-pop-ahead view of the head row so the
    // element output can be registered without adding latency.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        elem_d    = elem_q;
        frame_d   = 1'b0;
        count_nxt = count + 2'(push) - 2'(pop);
        ready_d   = (count_nxt != 2'd2);
        head_nxt  = head;

        if (pop) begin
            head_nxt = full ? second : dibit;
        end else if (empty) begin
            head_nxt = dibit;
        end

        if (xfer) begin
            col_d = last_col ? '0 : col_q + CA_W'(1);
        end

        if (pop) begin
            row_d   = (row_q == RA_W'(ROWS - 1)) ? '0 : row_q + RA_W'(1);
            frame_d = (row_q == RA_W'(ROWS - 1));
        end

        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (pop && (count_nxt == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == SHIFT) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (col_d == CA_W'(c)) begin
                    elem_d = head_nxt[c*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    assign ready_out      = ready_q;
    assign valid_data_out = (state_q == SHIFT);
    assign row_addr       = row_q;
    assign col_addr       = col_q;
    assign matrix_element = elem_q;
    assign frame_done     = frame_q;

endmodule

// File: tb/tb_matrix_decompiler.sv
// Self-checking bench for matrix_decompiler: element scoreboard, stall and
// frame_done monitors, a small table of single-row cases and directed sequences.
module tb_matrix_decompiler;

    localparam int unsigned ROWS   = 32;
    localparam int unsigned COLS   = 32;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned ROW_W  = COLS * ELEM_W;
    localparam int unsigned RAW    = 5;
    localparam int unsigned CAW    = 5;

    logic              eth_refclk = 1'b0;
    logic              rst_n;
    logic              valid_data_in;
    logic [ROW_W-1:0]  dibit;
    logic              ready_out;
    logic              valid_data_out;
    logic              ready_in;
    logic [RAW-1:0]    row_addr;
    logic [CAW-1:0]    col_addr;
    logic [ELEM_W-1:0] matrix_element;
    logic              frame_done;

    typedef struct packed {
        logic [RAW-1:0]    row;
        logic [CAW-1:0]    col;
        logic [ELEM_W-1:0] elem;
    } exp_t;

    typedef struct {
        logic [ROW_W-1:0]  row;
        logic              rdy;
        logic [ELEM_W-1:0] exp_elem;
        logic [RAW-1:0]    exp_row;
        logic              exp_ready;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[4];
    int   checks   = 0;
    int   errors   = 0;
    int   tb_row   = 0;
    int   fd_count = 0;

    matrix_decompiler #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ELEM_W (ELEM_W)
    ) dut (
        .eth_refclk     (eth_refclk),
        .rst_n          (rst_n),
        .valid_data_in  (valid_data_in),
        .dibit          (dibit),
        .ready_out      (ready_out),
        .valid_data_out (valid_data_out),
        .ready_in       (ready_in),
        .row_addr       (row_addr),
        .col_addr       (col_addr),
        .matrix_element (matrix_element),
        .frame_done     (frame_done)
    );

    always #5 eth_refclk = ~eth_refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1ms, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [ROW_W-1:0] inc_row();
        logic [ROW_W-1:0] d;
        for (int c = 0; c < COLS; c++) d[c*ELEM_W +: ELEM_W] = 8'(c);
        return d;
    endfunction

    function automatic logic [ROW_W-1:0] frame_row(input int r);
        logic [ROW_W-1:0] d;
        for (int c = 0; c < COLS; c++) d[c*ELEM_W +: ELEM_W] = {3'(r), 5'(c)};
        return d;
    endfunction

    task automatic push_row(input logic [ROW_W-1:0] d);
        for (int c = 0; c < COLS; c++) begin
            exp_t e;
            e.row  = RAW'(tb_row);
            e.col  = CAW'(c);
            e.elem = d[c*ELEM_W +: ELEM_W];
            exp_q.push_back(e);
        end
        tb_row = (tb_row + 1) % ROWS;
    endtask

    // Offer a row from posedge+1; returns the number of refused cycles.
    task automatic send_row(input logic [ROW_W-1:0] d, input int budget, output int waited);
        bit done;
        done          = 1'b0;
        waited        = -1;
        valid_data_in = 1'b1;
        dibit         = d;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge eth_refclk);
            if (ready_out) begin
                @(posedge eth_refclk);
                push_row(d);
                waited = i;
                done   = 1'b1;
            end else begin
                @(posedge eth_refclk);
            end
            #1;
        end
        valid_data_in = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance in %0d cycles, required acceptance", budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge eth_refclk);
            if (exp_q.size() == 0 && !valid_data_out) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending elements, required 0", exp_q.size());
        end
        @(posedge eth_refclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        valid_data_in = 1'b0;
        ready_in      = 1'b1;
        #1;
        exp_q.delete();
        tb_row = 0;
        repeat (2) @(posedge eth_refclk);
        #1;
        rst_n = 1'b1;
        @(posedge eth_refclk);
        #1;
    endtask

    // Scoreboard, stall-hold, no-bubble and frame_done monitor.
    exp_t held;
    logic stall_prev = 1'b0;
    logic final_prev = 1'b0;
    always @(negedge eth_refclk) begin
        exp_t got;
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
            final_prev = 1'b0;
        end else begin
            got = {row_addr, col_addr, matrix_element};
            check("frame_done", 32'(frame_done), 32'(final_prev));
            if (frame_done) fd_count++;
            if (stall_prev && valid_data_out) check("stall_hold", 32'(got), 32'(held));
            if (ready_in && exp_q.size() > 0) check("no_bubble", 32'(valid_data_out), 32'd1);
            if (valid_data_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_elem: got row %0d col %0d elem 0x%0h, required none",
                             row_addr, col_addr, matrix_element);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("element_r%0d_c%0d", e.row, e.col), 32'(got), 32'(e));
                end
            end
            final_prev = valid_data_out && ready_in && (row_addr == 5'd31) && (col_addr == 5'd31);
            stall_prev = valid_data_out && !ready_in;
            held       = got;
        end
    end

    initial begin
        logic [ROW_W-1:0] d;
        int w;
        int fd_before;
        bit found;

        tbl[0] = '{row: inc_row(), rdy: 1'b1, exp_elem: 8'h00, exp_row: 5'd0, exp_ready: 1'b1};
        tbl[1] = '{row: {COLS{8'hFF}}, rdy: 1'b0, exp_elem: 8'hFF, exp_row: 5'd1, exp_ready: 1'b1};
        tbl[2] = '{row: {(COLS/2){16'h5AA5}}, rdy: 1'b1, exp_elem: 8'hA5, exp_row: 5'd2, exp_ready: 1'b1};
        for (int c = 0; c < COLS; c++) d[c*ELEM_W +: ELEM_W] = 8'($urandom);
        tbl[3] = '{row: d, rdy: 1'b0, exp_elem: d[7:0], exp_row: 5'd3, exp_ready: 1'b1};

        rst_n         = 1'b0;
        valid_data_in = 1'b0;
        ready_in      = 1'b1;
        dibit         = '0;
        repeat (3) @(posedge eth_refclk);
        @(negedge eth_refclk);
        check("rst_valid", 32'(valid_data_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_row", 32'(row_addr), 32'd0);
        check("rst_col", 32'(col_addr), 32'd0);
        check("rst_elem", 32'(matrix_element), 32'd0);
        rst_n = 1'b1;
        @(posedge eth_refclk);
        #1;

        // Single rows into an idle block: first element the cycle after acceptance.
        for (int i = 0; i < 4; i++) begin
            ready_in = tbl[i].rdy;
            send_row(tbl[i].row, 10, w);
            @(negedge eth_refclk);
            check($sformatf("t%0d_valid", i), 32'(valid_data_out), 32'd1);
            check($sformatf("t%0d_elem", i), 32'(matrix_element), 32'(tbl[i].exp_elem));
            check($sformatf("t%0d_col", i), 32'(col_addr), 32'd0);
            check($sformatf("t%0d_row", i), 32'(row_addr), 32'(tbl[i].exp_row));
            check($sformatf("t%0d_ready", i), 32'(ready_out), 32'(tbl[i].exp_ready));
            @(posedge eth_refclk);
            #1;
            ready_in = 1'b1;
            wait_drain(200);
        end

        // Full frame, back-to-back rows.
        do_reset();
        fd_before = fd_count;
        for (int r = 0; r < ROWS; r++) send_row(frame_row(r), 100, w);
        wait_drain(200);
        check("frame_done_pulses", 32'(fd_count - fd_before), 32'd1);
        check("row_wrap", 32'(row_addr), 32'd0);

        // Backpressure: FIFO fills, third row held until row 1 completes.
        ready_in = 1'b0;
        send_row(frame_row(7), 10, w);
        send_row(~frame_row(7), 10, w);
        @(negedge eth_refclk);
        check("full_ready_low", 32'(ready_out), 32'd0);
        @(posedge eth_refclk);
        #1;
        valid_data_in = 1'b1;
        dibit         = inc_row();
        repeat (5) begin
            @(negedge eth_refclk);
            check("held_ready_low", 32'(ready_out), 32'd0);
        end
        @(posedge eth_refclk);
        #1;
        ready_in = 1'b1;
        send_row(inc_row(), 100, w);
        check("accept_wait", 32'(w), 32'd32);
        wait_drain(200);

        // Toggling downstream ready mid-row.
        send_row(frame_row(3), 10, w);
        send_row(frame_row(4), 10, w);
        repeat (5) @(posedge eth_refclk);
        #1;
        for (int i = 0; i < 60; i++) begin
            ready_in = ~ready_in;
            @(posedge eth_refclk);
            #1;
        end
        ready_in = 1'b1;
        wait_drain(200);

        // Reset mid-row with a row buffered.
        do_reset();
        for (int r = 0; r < 7; r++) send_row(frame_row(r + 9), 100, w);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge eth_refclk);
            if (valid_data_out && row_addr == 5'd5 && col_addr == 5'd17) found = 1'b1;
        end
        check("reach_r5_c17", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        tb_row = 0;
        @(negedge eth_refclk);
        check("midrst_valid", 32'(valid_data_out), 32'd0);
        check("midrst_ready", 32'(ready_out), 32'd1);
        @(posedge eth_refclk);
        #1;
        rst_n = 1'b1;
        @(posedge eth_refclk);
        #1;
        send_row(inc_row(), 10, w);
        @(negedge eth_refclk);
        check("postrst_row", 32'(row_addr), 32'd0);
        check("postrst_col", 32'(col_addr), 32'd0);
        check("postrst_valid", 32'(valid_data_out), 32'd1);
        @(posedge eth_refclk);
        #1;
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_decompiler.md
MATRIX_DECOMPILER -- requirements
Module: matrix_decompiler

Interface
REQ-001 The block SHALL run on one clock, eth_refclk, with asynchronous active-low reset rst_n; all flops SHALL reset on rst_n falling and release synchronously to eth_refclk.
REQ-002 Parameters (name, default, meaning):
- ROWS, 32, matrix rows per frame
- COLS, 32, elements per row
- ELEM_W, 8, bits per element
REQ-003 Ports (name, direction, width, meaning):
- eth_refclk  in  1  clock
- rst_n  in  1  async active-low reset
- valid_data_in  in  1  packed row present on dibit
- dibit  in  COLS*ELEM_W (256)  packed row; element c at bits [c*ELEM_W+ELEM_W-1 : c*ELEM_W]
- ready_out  out  1  block can accept a row this cycle
- valid_data_out  out  1  element outputs valid
- ready_in  in  1  downstream accepts element
- row_addr  out  $clog2(ROWS) (5)  row index of element
- col_addr  out  $clog2(COLS) (5)  column index of element
- matrix_element  out  ELEM_W (8)  element value
- frame_done  out  1  one-cycle pulse on transfer of element (ROWS-1, COLS-1)

Function
REQ-004 A row SHALL be accepted on a rising edge where valid_data_in && ready_out; valid_data_in with ready_out low SHALL have no effect, and the sender holds dibit.
REQ-005 Accepted rows SHALL enter a 2-entry row FIFO; ready_out SHALL be high exactly when the FIFO holds fewer than 2 rows, with no simultaneous-pop bypass when full.
REQ-006 Rows SHALL be numbered implicitly in acceptance order by a row counter 0..ROWS-1 that wraps ROWS-1 -> 0; the counter increments when a row's last element transfers.
REQ-007 The serializer FSM SHALL have states IDLE and SHIFT. IDLE -> SHIFT when the FIFO is non-empty. SHIFT -> IDLE after the col COLS-1 transfer if the FIFO is then empty. SHIFT -> SHIFT (next row, col 0) otherwise.
REQ-008 In SHIFT, valid_data_out SHALL be high. Elements SHALL be emitted in column order 0..COLS-1 from the head row. row_addr is the row counter, col_addr the column counter, and matrix_element is the head-row slice at col_addr.
REQ-009 An element SHALL transfer on a rising edge with valid_data_out && ready_in. The column counter then increments, and on col COLS-1 the head row is popped and the column counter returns to 0.
REQ-010 While valid_data_out && !ready_in, row_addr, col_addr and matrix_element SHALL hold stable.
REQ-011 Latency: the first element of a row accepted into an empty, idle block SHALL be valid on the cycle after acceptance.
REQ-012 Sustained throughput SHALL be one element per cycle with ready_in held high, with no bubble between consecutive rows when the next row is already buffered.
REQ-013 A FIFO push and a head-row pop on the same edge SHALL both take effect, with occupancy unchanged.
REQ-014 frame_done SHALL be registered and go high for exactly one cycle, the cycle after the transfer of row ROWS-1, col COLS-1.

Reset
REQ-015 On rst_n low the block SHALL reset to:
- FSM in IDLE; FIFO empty
- row and column counters 0
- ready_out 1 after reset, valid_data_out 0, frame_done 0
- row_addr 0, col_addr 0, matrix_element 0
REQ-016 Reset mid-row SHALL discard all buffered rows and the partial row; the first row accepted after reset SHALL be row 0.

Structure
REQ-017 Package matrix_pkg SHALL hold ROWS, COLS and ELEM_W defaults, the derived ROW_W, ROW_AW and COL_AW widths, and the FSM state enum; matrix_compiler and matrix_decompiler SHALL share it.
REQ-018 The 2-entry FIFO SHALL be a sub-module row_fifo (push/pop/full/empty, width ROW_W); the serializer and counters SHALL live in matrix_decompiler.

Verification
REQ-019 Single row with dibit byte c = c, ready_in=1 -> 32 consecutive valid cycles starting the cycle after acceptance; row_addr=0, col_addr=0..31, matrix_element=0x00..0x1F.
REQ-020 32 rows, row r byte c = {r[2:0],c}, back-to-back, ready_in=1 -> 1024 elements with no gaps; row_addr wraps 31 -> 0 after the frame; frame_done pulses once, one cycle after (31,31).
REQ-021 Push 3 rows while ready_in=0 -> ready_out drops after row 2; row 3 is held and not accepted; it is accepted after ready_in rises and row 1 completes.
REQ-022 Toggle ready_in every cycle mid-row -> outputs stable while stalled, no element lost or duplicated; column sequence 0..31 intact.
REQ-023 Assert rst_n low at row 5, col 17 with 1 row buffered -> the cycle after reset assertion, valid_data_out=0 and ready_out=1; the next accepted row emits row_addr=0, col_addr=0.
